// File: rtl/time_counter.sv
// Time-of-day counter. A prescaler divides the system clock down to a
// one-second tick that advances an hh:mm:ss value. Each field is stored as
// plain binary in one byte: {hours, minutes, seconds}. A rising edge on
// setup_imp loads a new time, with out-of-range fields forced to zero. halt
// freezes timekeeping but still accepts a load.
module time_counter #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] setup_data,
  input  logic        setup_imp,
  input  logic        halt,
  output logic [23:0] data_ch,
  output logic        sec_tick,
  output logic        day_wrap
);

  // Prescaler width: just enough bits to hold CLK_FREQ-1.
  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [23:0]   DAY_END   = 24'h17_3B_3B;  // 23:59:59

  logic [PW-1:0] presc;
  logic          setup_imp_d;
  logic          load_evt;
  logic          tick_evt;
  logic          wrap_evt;

  // Force each out-of-range field to zero. In-range fields pass through.
  function automatic logic [23:0] sanitize(input logic [23:0] t);
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    h = (t[23:16] > 8'd23) ? 8'd0 : t[23:16];
    m = (t[15:8]  > 8'd59) ? 8'd0 : t[15:8];
    s = (t[7:0]   > 8'd59) ? 8'd0 : t[7:0];
    return {h, m, s};
  endfunction

  // Add one second. All carries settle in a single step, so the result
  // never shows a transient value such as :60 or hour 24.
  function automatic logic [23:0] advance(input logic [23:0] t);
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    h = t[23:16];
    m = t[15:8];
    s = t[7:0];
    if (s == 8'd59) begin
      s = 8'd0;
      if (m == 8'd59) begin
        m = 8'd0;
        if (h == 8'd23) h = 8'd0;
        else            h = h + 8'd1;
      end else begin
        m = m + 8'd1;
      end
    end else begin
      s = s + 8'd1;
    end
    return {h, m, s};
  endfunction

  // A load fires only on the 0->1 transition of setup_imp. It overrides a
  // tick in the same cycle, so a coincident tick is simply dropped.
  assign load_evt = setup_imp & ~setup_imp_d;
  assign tick_evt = ~halt & ~load_evt & (presc == PRESC_MAX);
  assign wrap_evt = tick_evt & (data_ch == DAY_END);

  // Edge detector for setup_imp. It resets to 1, so a level that is already
  // high when reset is released is not seen as a new load request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) setup_imp_d <= 1'b1;
    else       setup_imp_d <= setup_imp;
  end

  // Prescaler. A load restarts the count, so the next second boundary
  // falls one full second after the load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (load_evt) begin
      presc <= '0;
    end else if (!halt) begin
      if (presc == PRESC_MAX) presc <= '0;
      else                    presc <= presc + PRESC_ONE;
    end
  end

  // Time register: a load wins over a tick, and a tick advances one second.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         data_ch <= 24'h00_00_00;
    else if (load_evt) data_ch <= sanitize(setup_data);
    else if (tick_evt) data_ch <= advance(data_ch);
  end

  // Status pulses, registered so they line up with the data_ch update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      sec_tick <= tick_evt;
      day_wrap <= wrap_evt;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter with CLK_FREQ=4. The stimulus process drives the
// inputs shortly after each rising edge. Whenever it expects a particular
// output, it queues the expected {data_ch, sec_tick, day_wrap} together with
// the number of the cycle it applies to. A separate monitor samples the
// outputs on every falling edge and compares them with the queued entry.
module tb_time_counter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] setup_data = 24'h0;
  logic        setup_imp = 1'b0;
  logic        halt = 1'b0;
  logic [23:0] data_ch;
  logic        sec_tick;
  logic        day_wrap;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] id;
    logic [23:0] d;
    logic        tk;
    logic        wr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cyc = '0;
  logic [31:0] vid = '0;
  logic        stim_done = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  time_counter #(.CLK_FREQ(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .setup_data (setup_data),
    .setup_imp  (setup_imp),
    .halt       (halt),
    .data_ch    (data_ch),
    .sec_tick   (sec_tick),
    .day_wrap   (day_wrap)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_now(input logic [23:0] d, input logic tk, input logic wr);
    exp_t e;
    e.cyc = cyc;
    e.id  = vid;
    e.d   = d;
    e.tk  = tk;
    e.wr  = wr;
    vid   = vid + 1;
    sb.push_back(e);
  endtask

  // Monitor and scoreboard: compare once per cycle on the falling edge.
  initial begin
    int   drain;
    exp_t e;
    drain = 0;
    forever begin
      @(negedge clock);
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL vec%0d not sampled: cycle %0d passed, now at cycle %0d", e.id, e.cyc, cyc);
      end
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_vec++;
        if (data_ch !== e.d || sec_tick !== e.tk || day_wrap !== e.wr) begin
          n_err++;
          $display("FAIL vec%0d cyc%0d: got data_ch=%06h sec_tick=%b day_wrap=%b, want data_ch=%06h sec_tick=%b day_wrap=%b",
                   e.id, cyc, data_ch, sec_tick, day_wrap, e.d, e.tk, e.wr);
        end
      end
      if (stim_done) begin
        if (sb.size() == 0 || drain >= 20) begin
          while (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL vec%0d timeout: never compared (due cycle %0d)", e.id, e.cyc);
          end
          $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
          $finish;
        end
        drain++;
      end
    end
  end

  // Stimulus
  initial begin
    // Reset state while reset is held.
    step(2);
    expect_now(24'h000000, 1'b0, 1'b0);

    // Release reset: three quiet cycles, then the first tick on the 4th edge.
    reset = 1'b0;
    step(3);
    expect_now(24'h000000, 1'b0, 1'b0);
    step(1);
    expect_now(24'h000001, 1'b1, 1'b0);
    step(1);                                   // prescaler = 1
    expect_now(24'h000001, 1'b0, 1'b0);

    // 23:59:58 loaded, setup_imp held for 10 edges: only one load happens.
    setup_data = 24'h17_3B_3A;
    setup_imp  = 1'b1;
    step(1);                                   // load, prescaler = 0
    expect_now(24'h173B3A, 1'b0, 1'b0);
    step(3);
    expect_now(24'h173B3A, 1'b0, 1'b0);
    step(1);
    expect_now(24'h173B3B, 1'b1, 1'b0);
    step(3);
    expect_now(24'h173B3B, 1'b0, 1'b0);
    step(1);                                   // 8 edges after the load
    expect_now(24'h000000, 1'b1, 1'b1);
    step(1);                                   // prescaler = 1
    expect_now(24'h000000, 1'b0, 1'b0);
    setup_imp = 1'b0;
    step(1);

    // Load a plain value, then loads with out-of-range fields.
    setup_data = 24'h05_06_07;
    setup_imp  = 1'b1;
    step(1);
    expect_now(24'h050607, 1'b0, 1'b0);
    setup_imp = 1'b0;
    step(1);
    setup_data = 24'h18_3C_3C;
    setup_imp  = 1'b1;
    step(1);
    expect_now(24'h000000, 1'b0, 1'b0);
    setup_imp = 1'b0;
    step(1);
    setup_data = 24'h0A_3C_05;
    setup_imp  = 1'b1;
    step(1);
    expect_now(24'h0A0005, 1'b0, 1'b0);
    setup_imp = 1'b0;
    step(1);
    setup_data = 24'h17_3B_3B;                 // all fields at their maximum
    setup_imp  = 1'b1;
    step(1);                                   // prescaler = 0
    expect_now(24'h173B3B, 1'b0, 1'b0);
    setup_imp = 1'b0;

    // Count to prescaler = 2, halt for 20 cycles, tick 2 cycles after release.
    step(2);
    expect_now(24'h173B3B, 1'b0, 1'b0);
    halt = 1'b1;
    step(10);
    expect_now(24'h173B3B, 1'b0, 1'b0);
    step(10);
    expect_now(24'h173B3B, 1'b0, 1'b0);
    halt = 1'b0;
    step(1);
    expect_now(24'h173B3B, 1'b0, 1'b0);
    step(1);
    expect_now(24'h000000, 1'b1, 1'b1);

    // Load while halted with prescaler = 2: prescaler clears and stays 0.
    step(2);
    halt       = 1'b1;
    setup_data = 24'h01_02_03;
    setup_imp  = 1'b1;
    step(1);
    expect_now(24'h010203, 1'b0, 1'b0);
    setup_imp = 1'b0;
    step(5);
    expect_now(24'h010203, 1'b0, 1'b0);
    halt = 1'b0;
    step(3);
    expect_now(24'h010203, 1'b0, 1'b0);
    step(1);
    expect_now(24'h010204, 1'b1, 1'b0);

    // Load rising edge coincides with prescaler = 3: load wins, no tick.
    step(3);
    expect_now(24'h010204, 1'b0, 1'b0);
    setup_data = 24'h0B_0C_0D;
    setup_imp  = 1'b1;
    step(1);
    expect_now(24'h0B0C0D, 1'b0, 1'b0);
    setup_imp = 1'b0;
    step(3);
    expect_now(24'h0B0C0D, 1'b0, 1'b0);
    step(1);
    expect_now(24'h0B0C0E, 1'b1, 1'b0);

    // Hour carry without a day wrap.
    setup_data = 24'h0A_3B_3B;
    setup_imp  = 1'b1;
    step(1);
    expect_now(24'h0A3B3B, 1'b0, 1'b0);
    setup_imp = 1'b0;
    step(3);
    step(1);
    expect_now(24'h0B0000, 1'b1, 1'b0);

    // Reset mid-count with setup_imp high. Reset takes effect at once, and
    // the level held through release must not load.
    step(2);                                   // prescaler = 2
    reset     = 1'b1;
    setup_imp = 1'b1;
    expect_now(24'h000000, 1'b0, 1'b0);
    setup_data = 24'h0C_0D_0E;
    step(2);
    reset = 1'b0;
    step(3);
    expect_now(24'h000000, 1'b0, 1'b0);
    step(1);
    expect_now(24'h000001, 1'b1, 1'b0);
    setup_imp = 1'b0;
    step(1);
    setup_imp = 1'b1;
    step(1);
    expect_now(24'h0C0D0E, 1'b0, 1'b0);
    setup_imp = 1'b0;
    step(2);

    stim_done = 1'b1;
  end

  // Hard bound on the run in case the monitor never reaches its summary.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter: CLK_FREQ, default 50000000, clock cycles per second (legal range 2..2^26).
REQ-002 Port: clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: setup_data  in  24  time to load, {hours[23:16], minutes[15:8], seconds[7:0]}, binary per byte.
REQ-005 Port: setup_imp  in  1  load request; level signal that may stay high for many cycles.
REQ-006 Port: halt  in  1  freeze request; while high, timekeeping is suspended.
REQ-007 Port: data_ch  out  24  current time, same packing as setup_data, registered.
REQ-008 Port: sec_tick  out  1  one-cycle pulse, high in the cycle data_ch advances by one second.
REQ-009 Port: day_wrap  out  1  one-cycle pulse, high in the cycle data_ch wraps from 23:59:59 to 00:00:00.

Function
REQ-010 The block SHALL contain a prescaler counting 0..CLK_FREQ-1, sized to ceil(log2(CLK_FREQ)) bits.
REQ-011 With halt=0 and no load, the prescaler SHALL increment each cycle, and at CLK_FREQ-1 SHALL wrap to 0 and advance the time by one second on that edge.
REQ-012 With halt=1, the prescaler, data_ch and both pulse outputs SHALL hold or stay low, with no tick generated.
REQ-013 Seconds SHALL count 0..59; 59 -> 0 with a minute carry.
REQ-014 Minutes SHALL count 0..59; 59 -> 0 with an hour carry when a carry arrives.
REQ-015 Hours SHALL count 0..23; 23 -> 0 when a carry arrives, with day_wrap=1 for that cycle.
REQ-016 All carries SHALL resolve in the same edge; there is no intermediate state such as 23:59:60 or 24:00:00.
REQ-017 setup_imp SHALL be registered into setup_imp_d each cycle.
REQ-018 A load event SHALL be defined as setup_imp=1 with setup_imp_d=0, i.e. exactly one load per rising level.
REQ-019 On a load event, data_ch SHALL take setup_data at that same clock edge (zero-cycle latency to the registered output).
REQ-020 On a load event, the prescaler SHALL clear to 0, so the next tick occurs exactly CLK_FREQ cycles later.
REQ-021 Load sanitising, per field: seconds>59 -> 0; minutes>59 -> 0; hours>23 -> 0. Other fields SHALL load unchanged.
REQ-022 A load SHALL take priority over a tick in the same cycle: the loaded value wins, there is no increment, and sec_tick=0 and day_wrap=0.
REQ-023 A load SHALL be accepted while halt=1.
REQ-024 While halt stays high after such a load, the prescaler SHALL remain 0.
REQ-025 sec_tick and day_wrap SHALL be registered and never high for more than one consecutive cycle at CLK_FREQ>=2.

Reset
REQ-026 While reset=1 (asynchronously): data_ch=24'h000000, prescaler=0, sec_tick=0, day_wrap=0.
REQ-027 While reset=1, setup_imp_d SHALL be held at 1.
REQ-028 Because setup_imp_d resets to 1, a setup_imp held high through reset release SHALL NOT load; a new 0->1 transition is required.
REQ-029 Reset asserted mid-count SHALL discard the partial prescaler count.
REQ-030 After reset release, the first tick SHALL occur CLK_FREQ cycles later.

Verification (CLK_FREQ=4)
REQ-031 Release reset, halt=0 -> data_ch=000000 for 3 cycles; sec_tick pulse on the 4th edge with data_ch=000001.
REQ-032 Load 17_3B_3A (23:59:58) with setup_imp held 10 cycles -> exactly one load; after 8 cycles data_ch=000000 with day_wrap=1 and sec_tick=1 for one cycle.
REQ-033 Load 18_3C_3C -> data_ch=000000; load 0A_3C_05 -> data_ch=0A_00_05.
REQ-034 Count to prescaler=2, then halt=1 for 20 cycles -> data_ch and prescaler frozen; after halt=0 the tick comes 2 cycles later.
REQ-035 Load rising edge coincides with prescaler=3 -> data_ch=setup_data, no increment, sec_tick=0; next tick 4 cycles later.
REQ-036 Assert reset mid-count with setup_imp=1, then release -> data_ch=000000, no load; a subsequent setup_imp 0->1 loads.
